// File: rtl/mdu_pkg.sv
// mdu_pkg
//   Shared definitions for the HI/LO multiply/divide unit:
//     - MDU_WIDTH          default operand/result width
//     - MDU_MULT..MDU_DIVU 2-bit operation encodings seen on the op port
//     - ST_IDLE/RUN/FIN    FSM state encodings
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/mdu_step.sv
// mdu_step
//   Combinational single radix-2 iteration, operating on unsigned magnitudes.
//   Multiply (shift-add): {upper,lower} holds partial product / multiplier;
//     if lower[0] the multiplicand is added to upper, then the pair shifts right.
//   Divide (restoring): upper is the partial remainder, lower the dividend
//     being shifted out while quotient bits shift in at the bottom.
// Ports
//   is_div      in   1      select divide step (else multiply step)
//   upper       in   WIDTH  partial product high half / partial remainder
//   lower       in   WIDTH  multiplier+low product / dividend+quotient
//   operand     in   WIDTH  multiplicand or divisor magnitude
//   next_upper  out  WIDTH  upper after this iteration
//   next_lower  out  WIDTH  lower after this iteration
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_upper,
  output logic [WIDTH-1:0] next_lower
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The remainder is always below the divisor, so the trial difference fits
  // in WIDTH bits whenever the subtraction succeeds; only the compare needs
  // the extra bit of the shifted remainder.
  always_comb begin
    sum        = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted    = {upper, lower[WIDTH-1]};
    fits       = (shifted >= {1'b0, operand});
    diff       = shifted[WIDTH-1:0] - operand;
    next_upper = sum[WIDTH:1];
    next_lower = {sum[0], lower[WIDTH-1:1]};
    if (is_div) begin
      next_upper = fits ? diff : shifted[WIDTH-1:0];
      next_lower = {lower[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//   Operands are converted to magnitudes at launch, WIDTH radix-2 steps run
//   in mdu_step, and the sign fix-up is applied when HI/LO are written.
//   Optional build macro MDU_DIV0_FLAG_EN adds the div0 output.
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      launch op (sampled only when idle)
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   WIDTH  rs operand; also MTHI/MTLO data
//   b      in   WIDTH  rt operand
//   hi_we  in   1      MTHI when idle
//   lo_we  in   1      MTLO when idle
//   busy   out  1      op in flight
//   done   out  1      1-cycle pulse when HI/LO updated
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
//   div0   out  1      (MDU_DIV0_FLAG_EN only) finished op was divide by zero
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div_r;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic [WIDTH-1:0] operand_r;
  logic [WIDTH-1:0] upper_r;
  logic [WIDTH-1:0] lower_r;

  logic             op_div;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_upper;
  logic [WIDTH-1:0] step_lower;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  assign busy = (state != ST_IDLE);

  // Launch-time decode: magnitudes of the operands and their signs.
  // The most negative value maps to itself, which is the correct unsigned
  // magnitude once read as WIDTH-bit unsigned.
  always_comb begin
    op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    sign_a    = op_signed & a[WIDTH-1];
    sign_b    = op_signed & b[WIDTH-1];
    abs_a     = sign_a ? (~a + 1'b1) : a;
    abs_b     = sign_b ? (~b + 1'b1) : b;
  end

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div    (is_div_r),
    .upper     (upper_r),
    .lower     (lower_r),
    .operand   (operand_r),
    .next_upper(step_upper),
    .next_lower(step_lower)
  );

  // Sign fix-up applied on the way into HI/LO. With a zero divisor the
  // restoring loop never fails a trial subtract, so the remainder ends up
  // holding |a| unchanged; restoring the dividend sign recovers a itself,
  // while the quotient is forced to all-ones regardless of sign.
  always_comb begin
    prod_fix = {upper_r, lower_r};
    if (neg_q) begin
      prod_fix = ~{upper_r, lower_r} + 1'b1;
    end
    hi_next = prod_fix[2*WIDTH-1:WIDTH];
    lo_next = prod_fix[WIDTH-1:0];
    if (is_div_r) begin
      hi_next = neg_r ? (~upper_r + 1'b1) : upper_r;
      lo_next = neg_q ? (~lower_r + 1'b1) : lower_r;
      if (zero_div) begin
        lo_next = {WIDTH{1'b1}};
      end
    end
  end

  // Control FSM plus all architectural and working registers. A start in
  // IDLE takes priority over MTHI/MTLO in the same cycle; HI/LO are only
  // written on the FIN cycle so intermediate values never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_div_r  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_div  <= 1'b0;
      operand_r <= '0;
      upper_r   <= '0;
      lower_r   <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0 <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            cnt       <= '0;
            is_div_r  <= op_div;
            neg_q     <= sign_a ^ sign_b;
            neg_r     <= op_div & sign_a;
            zero_div  <= op_div & (b == '0);
            operand_r <= abs_b;
            upper_r   <= '0;
            lower_r   <= abs_a;
          end else begin
            if (hi_we) begin
              hi <= a;
            end
            if (lo_we) begin
              lo <= a;
            end
          end
        end
        ST_RUN: begin
          upper_r <= step_upper;
          lower_r <= step_lower;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          hi    <= hi_next;
          lo    <= lo_next;
          done  <= 1'b1;
          state <= ST_IDLE;
`ifdef MDU_DIV0_FLAG_EN
          div0  <= zero_div;
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed self-checking bench for mult_div_unit: reset, each op type,
//   divide overflow and divide by zero, MTHI/MTLO gating, async reset
//   mid-operation and start-while-busy.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_DIV0_FLAG_EN
  logic        div0;
`endif

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
`ifdef MDU_DIV0_FLAG_EN
    ,
    .div0 (div0)
`endif
  );

  always #5 clk = ~clk;

  // Drive one start pulse sampled at the next rising edge; returns just after it.
  task automatic launch(input logic [1:0] op_in, input logic [31:0] a_in, input logic [31:0] b_in);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = op_in;
    a     = a_in;
    b     = b_in;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count busy cycles (sampled on falling edges) until done or a cycle budget runs out.
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int  cyc;
    bit  seen;
    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL multu_done got=%b exp=1", seen); end
    total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=33", cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL multu_busy_at_done got=%b exp=0", busy); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL multu_hi got=%h exp=fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("[TB] FAIL multu_lo got=%h exp=00000001", lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL multu_done_pulse got=%b exp=0", done); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL multu_hi_hold got=%h exp=fffffffe", hi); end
  endtask

  task automatic test_mult();
    int  cyc;
    bit  seen;
    launch(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL mult_done got=%b exp=1", seen); end
    total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL mult_busy_cycles got=%0d exp=33", cyc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("[TB] FAIL mult_lo got=%h exp=ffffffeb", lo); end
  endtask

  task automatic test_div();
    int  cyc;
    bit  seen;
    launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL div_done got=%b exp=1", seen); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL div_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL div_hi got=%h exp=ffffffff", hi); end
`ifdef MDU_DIV0_FLAG_EN
    total++; if (div0 !== 1'b0) begin bad++; $display("[TB] FAIL div_div0 got=%b exp=0", div0); end
`endif
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  seen;
    launch(MDU_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL midrst_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL midrst_lo got=%h exp=0", lo); end
    @(negedge clk);
    #3 rst = 1'b0;
    launch(MDU_DIVU, 32'd1000, 32'd7);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = MDU_MULTU;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL midrst_rerun_done got=%b exp=1", seen); end
    total++; if (cyc !== 31) begin bad++; $display("[TB] FAIL midrst_rerun_busy got=%0d exp=31", cyc); end
    total++; if (lo !== 32'd142) begin bad++; $display("[TB] FAIL midrst_rerun_lo got=%h exp=0000008e", lo); end
    total++; if (hi !== 32'd6) begin bad++; $display("[TB] FAIL midrst_rerun_hi got=%h exp=00000006", hi); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ignored_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_div_zero();
    int  cyc;
    bit  seen;
    launch(MDU_DIVU, 32'd100, 32'd0);
    wait_done(cyc, seen);
    total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL div0_busy_cycles got=%0d exp=33", cyc); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL div0_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'd100) begin bad++; $display("[TB] FAIL div0_hi got=%h exp=00000064", hi); end
`ifdef MDU_DIV0_FLAG_EN
    total++; if (div0 !== 1'b1) begin bad++; $display("[TB] FAIL div0_flag got=%b exp=1", div0); end
`endif
    launch(MDU_DIV, 32'hFFFF_FFF6, 32'd0);
    wait_done(cyc, seen);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sdiv0_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FFF6) begin bad++; $display("[TB] FAIL sdiv0_hi got=%h exp=fffffff6", hi); end
  endtask

  task automatic test_overflow();
    int  cyc;
    bit  seen;
    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL ovf_done got=%b exp=1", seen); end
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("[TB] FAIL ovf_lo got=%h exp=80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL ovf_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int  cyc;
    bit  seen;
    launch(MDU_MULTU, 32'd5, 32'd6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      hi_we = 1'b1;
      lo_we = 1'b1;
      a     = 32'h1234;
    end
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wait_done(cyc, seen);
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL busy_mthi_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'd30) begin bad++; $display("[TB] FAIL busy_mtlo_lo got=%h exp=0000001e", lo); end
    @(posedge clk);
    #1;
    hi_we = 1'b1;
    a     = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b1;
    a     = 32'hABCD;
    @(negedge clk);
    total++; if (hi !== 32'h1234) begin bad++; $display("[TB] FAIL mthi_hi got=%h exp=00001234", hi); end
    total++; if (lo !== 32'd30) begin bad++; $display("[TB] FAIL mthi_lo_hold got=%h exp=0000001e", lo); end
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    @(negedge clk);
    total++; if (lo !== 32'hABCD) begin bad++; $display("[TB] FAIL mtlo_lo got=%h exp=0000abcd", lo); end
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = MDU_MULTU;
    a     = 32'd2;
    b     = 32'd3;
    hi_we = 1'b1;
    lo_we = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL start_wins_busy got=%b exp=1", busy); end
    total++; if (hi !== 32'h1234) begin bad++; $display("[TB] FAIL start_wins_hi got=%h exp=00001234", hi); end
    total++; if (lo !== 32'hABCD) begin bad++; $display("[TB] FAIL start_wins_lo got=%h exp=0000abcd", lo); end
    wait_done(cyc, seen);
    total++; if (lo !== 32'd6) begin bad++; $display("[TB] FAIL start_wins_result_lo got=%h exp=00000006", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL start_wins_result_hi got=%h exp=00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_reset_mid();
    test_div_zero();
    test_overflow();
    test_mthi_mtlo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
